// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC register, imem request FSM, instruction register.
// Optional request timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_go,
    input  logic        pc_upd,
    input  logic        pc_src,
    input  logic [63:0] imm,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [63:0] pc,
    output logic        instr_valid,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [63:0] target;
    logic        misaligned;
    logic        pc_we;
    logic        instr_we;
    logic        fault_set;
    logic        timed_out;

    assign target     = pc_src ? (pc + imm) : (pc + 64'd4);
    assign misaligned = (target[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] to_cnt;

    // Counts REQ cycles already spent without an ack; cleared outside REQ.
    always_ff @(posedge clk) begin
        if (rst_n || state != REQ) begin
            to_cnt <= '0;
        end else if (!timed_out) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timed_out = (to_cnt == CW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pc_we      = 1'b0;
        instr_we   = 1'b0;
        fault_set  = 1'b0;
        case (state)
            IDLE: begin
                // A pc update takes priority; a simultaneous fetch request is dropped.
                if (pc_upd) begin
                    if (misaligned) begin
                        fault_set  = 1'b1;
                        next_state = ERR;
                    end else begin
                        pc_we = 1'b1;
                    end
                end else if (fetch_go) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    instr_we   = 1'b1;
                    next_state = DONE;
                end else if (timed_out) begin
                    fault_set  = 1'b1;
                    next_state = ERR;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc    <= RESET_PC;
            instr <= 32'h0;
            fault <= 1'b0;
        end else begin
            if (pc_we) begin
                pc <= target;
            end
            if (instr_we) begin
                instr <= imem_rdata;
            end
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == DONE);
    assign busy        = (state != IDLE);
    assign opcode      = instr[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized transaction-level bench for instr_fetch.
module tb_instr_fetch;

    localparam int TO_CYC = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_go;
    logic        pc_upd;
    logic        pc_src;
    logic [63:0] imm;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [63:0] pc;
    logic        instr_valid;
    logic        busy;
    logic        fault;

    int vectors = 0;
    int errors  = 0;

    // expected architectural state
    logic [63:0] m_pc;
    logic [31:0] m_instr;

    instr_fetch #(.RESET_PC(64'h0), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_go(fetch_go), .pc_upd(pc_upd),
        .pc_src(pc_src), .imm(imm), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .opcode(opcode), .pc(pc), .instr_valid(instr_valid), .busy(busy),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_go   = 1'b0;
        pc_upd     = 1'b0;
        pc_src     = 1'b0;
        imm        = 64'h0;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req"}, imem_req, 0);
        check({tag, "_vld"}, instr_valid, 0);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_addr"}, imem_addr, m_pc);
        check({tag, "_instr"}, instr, m_instr);
        check({tag, "_opc"}, opcode, m_instr[6:0]);
        check({tag, "_fault"}, fault, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b1;
        step();
        rst_n   = 1'b0;
        m_pc    = 64'h0;
        m_instr = 32'h0;
        check_idle("reset");
    endtask

    // Fetch with 'lat' ack-less REQ cycles; noise pulses during the wait must be ignored.
    task automatic do_fetch(input int lat, input logic [31:0] data, input bit noise);
        idle_inputs();
        fetch_go = 1'b1;
        step();
        idle_inputs();
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, m_pc);
        check("fetch_busy", busy, 1);
        check("fetch_novld", instr_valid, 0);
        for (int i = 0; i < lat; i++) begin
            if (noise) begin
                fetch_go = 1'($urandom);
                pc_upd   = 1'($urandom);
                pc_src   = 1'($urandom);
                imm      = {$urandom, $urandom};
            end
            step();
            idle_inputs();
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, m_pc);
            check("wait_novld", instr_valid, 0);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        idle_inputs();
        m_instr = data;
        check("done_vld", instr_valid, 1);
        check("done_instr", instr, m_instr);
        check("done_opc", opcode, m_instr[6:0]);
        check("done_req", imem_req, 0);
        if (noise) begin
            fetch_go = 1'($urandom);
            pc_upd   = 1'($urandom);
            imem_ack = 1'($urandom);
        end
        step();
        idle_inputs();
        check_idle("post");
    endtask

    // Returns 1 when the update was misaligned and the unit is now in error.
    task automatic do_upd(input logic src, input logic [63:0] off, input logic go, output bit err);
        logic [63:0] tgt;
        tgt = src ? (m_pc + off) : (m_pc + 64'd4);
        idle_inputs();
        pc_upd   = 1'b1;
        pc_src   = src;
        imm      = off;
        fetch_go = go;
        step();
        idle_inputs();
        err = (tgt % 4) != 0;
        if (err) begin
            check("err_pc", pc, m_pc);
            check("err_fault", fault, 1);
            check("err_busy", busy, 1);
            check("err_req", imem_req, 0);
        end else begin
            m_pc = tgt;
            check_idle("upd");
        end
    endtask

    task automatic idle_noise();
        idle_inputs();
        imem_ack = 1'($urandom);
        step();
        check_idle("noise");
    endtask

    initial begin
        bit err;
        rst_n = 1'b0;
        idle_inputs();
        do_reset();

        // basic fetch: ack 2 cycles after fetch_go
        do_fetch(1, 32'h00A00093, 1'b0);
        check("basic_opc", opcode, 7'b0010011);

        // branch back by 8, then sequential step
        do_upd(1'b1, 64'h100, 1'b0, err);
        do_upd(1'b1, -64'sd8, 1'b0, err);
        check("br_back", pc, 64'hF8);
        do_upd(1'b0, 64'h0, 1'b0, err);
        check("seq_step", pc, 64'hFC);

        // wrap at top of address space
        do_upd(1'b1, 64'hFFFF_FFFF_FFFF_FFFC - m_pc, 1'b0, err);
        do_upd(1'b0, 64'h0, 1'b0, err);
        check("wrap_pc", pc, 64'h0);
        check("wrap_fault", fault, 0);

        // pc_upd wins over simultaneous fetch_go
        do_upd(1'b0, 64'h0, 1'b1, err);
        step();
        check("prio_req", imem_req, 0);
        check("prio_pc", pc, m_pc);

        // randomized mix of fetches, aligned updates and idle noise
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(2, 0))
                0: do_fetch($urandom_range(10, 0), $urandom, 1'($urandom));
                1: do_upd(1'($urandom), {$urandom, $urandom} & ~64'h3, 1'($urandom), err);
                default: idle_noise();
            endcase
        end

        // reset while a request is pending with an ack in the same cycle
        do_upd(1'b1, 64'h40, 1'b0, err);
        do_fetch(0, 32'h12345677, 1'b0);
        idle_inputs();
        fetch_go = 1'b1;
        step();
        idle_inputs();
        check("mid_req", imem_req, 1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        rst_n      = 1'b1;
        step();
        rst_n = 1'b0;
        idle_inputs();
        m_pc    = 64'h0;
        m_instr = 32'h0;
        check_idle("midrst");
        step();
        check("midrst_novld", instr_valid, 0);

        // misaligned target -> sticky error until reset
        do_upd(1'b1, 64'h6, 1'b0, err);
        check("mis_err", 64'(err), 1);
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            fetch_go = 1'($urandom);
            pc_upd   = 1'($urandom);
            pc_src   = 1'($urandom);
            imm      = {$urandom, $urandom};
            imem_ack = 1'($urandom);
            step();
            check("errhold_req", imem_req, 0);
            check("errhold_busy", busy, 1);
            check("errhold_fault", fault, 1);
            check("errhold_pc", pc, m_pc);
            check("errhold_vld", instr_valid, 0);
        end
        do_reset();

        // random misaligned offsets
        for (int n = 0; n < 8; n++) begin
            do_upd(1'b1, {$urandom, $urandom} | 64'h1, 1'b0, err);
            check("rmis_err", 64'(err), 1);
            do_reset();
        end

        // request that never gets an ack
        idle_inputs();
        fetch_go = 1'b1;
        step();
        idle_inputs();
`ifdef FETCH_TIMEOUT_EN
        for (int i = 1; i < TO_CYC; i++) begin
            step();
            check("to_wait_req", imem_req, 1);
            check("to_wait_fault", fault, 0);
        end
        step();
        check("to_req", imem_req, 0);
        check("to_fault", fault, 1);
        check("to_busy", busy, 1);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            if (i % 10 == 9) begin
                check("hang_req", imem_req, 1);
                check("hang_fault", fault, 0);
            end
        end
`endif
        do_reset();
        do_fetch(2, 32'hCAFE0013, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
